// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline control sequencer: FSM states,
// RV32 opcode constants, ALU op codes and control-vector bit indices.
package pipe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_LOAD2  = 3'd2,
    ST_BUBBLE = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  localparam logic [6:0]  OP_R        = 7'b0110011;
  localparam logic [6:0]  OP_IMM      = 7'b0010011;
  localparam logic [6:0]  OP_LOAD     = 7'b0000011;
  localparam logic [6:0]  OP_STORE    = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH   = 7'b1100011;
  localparam logic [31:0] INST_EBREAK = 32'h00100073;

  localparam logic [3:0]  ALU_ADD = 4'b0000;
  localparam logic [3:0]  ALU_SUB = 4'b1000;

  // Control vector is ascending [0:12]; the ALU op field sits at [7:10]
  // with the op MSB at index 7.
  localparam int CTRL_W       = 13;
  localparam int CTRL_PC_SEL  = 0;
  localparam int CTRL_REG_WR  = 1;
  localparam int CTRL_IMM_SB  = 5;
  localparam int CTRL_ALU_SRC = 6;
  localparam int CTRL_OP_MSB  = 7;
  localparam int CTRL_OP_LSB  = 10;
  localparam int CTRL_DMEM_WR = 11;
  localparam int CTRL_WB_DMEM = 12;

  typedef logic [0:CTRL_W-1] ctrl_t;

  // Control word for the writeback cycle of a load.
  function automatic ctrl_t load2_ctrl();
    ctrl_t c;
    c = '0;
    c[CTRL_REG_WR]  = 1'b1;
    c[CTRL_WB_DMEM] = 1'b1;
    c[CTRL_ALU_SRC] = 1'b1;
    c[CTRL_OP_MSB:CTRL_OP_LSB] = ALU_ADD;
    return c;
  endfunction

endpackage

// File: rtl/pipe_decode.sv
// Pure combinational decode of an RV32 instruction word into the datapath
// control vector, plus classification flags used by the sequencer FSM.
module pipe_decode
  import pipe_pkg::*;
(
  input  logic [31:0] inst,
  input  logic        alu_zero,
  output ctrl_t       ctrl,
  output logic        is_load,
  output logic        is_ebreak,
  output logic        is_illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;

  assign opcode    = inst[6:0];
  assign funct3    = inst[14:12];
  assign funct7_b5 = inst[30];

  // Opcode/funct to control mapping; undecodable words leave ctrl at 0.
  always_comb begin
    ctrl       = '0;
    is_load    = 1'b0;
    is_ebreak  = 1'b0;
    is_illegal = 1'b0;
    if (inst == INST_EBREAK) begin
      is_ebreak = 1'b1;
    end else begin
      case (opcode)
        OP_R: begin
          ctrl[CTRL_REG_WR] = 1'b1;
          ctrl[CTRL_OP_MSB:CTRL_OP_LSB] = {funct7_b5, funct3};
        end
        OP_IMM: begin
          ctrl[CTRL_REG_WR]  = 1'b1;
          ctrl[CTRL_ALU_SRC] = 1'b1;
          // Only SRAI uses bit 30 as an op modifier; for other I-ALU ops
          // bit 30 is just immediate data.
          if (funct3 == 3'b101 && funct7_b5)
            ctrl[CTRL_OP_MSB:CTRL_OP_LSB] = 4'b1101;
          else
            ctrl[CTRL_OP_MSB:CTRL_OP_LSB] = {1'b0, funct3};
        end
        OP_LOAD: begin
          if (funct3 == 3'b010) begin
            ctrl[CTRL_ALU_SRC] = 1'b1;
            ctrl[CTRL_OP_MSB:CTRL_OP_LSB] = ALU_ADD;
            is_load = 1'b1;
          end else begin
            is_illegal = 1'b1;
          end
        end
        OP_STORE: begin
          if (funct3 == 3'b010) begin
            ctrl[CTRL_DMEM_WR] = 1'b1;
            ctrl[CTRL_IMM_SB]  = 1'b1;
            ctrl[CTRL_ALU_SRC] = 1'b1;
            ctrl[CTRL_OP_MSB:CTRL_OP_LSB] = ALU_ADD;
          end else begin
            is_illegal = 1'b1;
          end
        end
        OP_BRANCH: begin
          if (funct3[2:1] == 2'b00) begin
            ctrl[CTRL_IMM_SB] = 1'b1;
            ctrl[CTRL_OP_MSB:CTRL_OP_LSB] = ALU_SUB;
            // BEQ taken on zero, BNE taken on non-zero.
            ctrl[CTRL_PC_SEL] = alu_zero ^ funct3[0];
          end else begin
            is_illegal = 1'b1;
          end
        end
        default: is_illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Control sequencer for the three-stage RV32 pipeline. Sequences issue,
// load writeback, post-branch bubble and halt. Optional retired-instruction
// counter built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [31:0] inst,
  input  logic        alu_zero,
  output logic [0:12] ctrl,
  output logic        pc_en,
  output logic        halted,
  output logic        illegal
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] retired
`endif
);

  state_t state, state_next;
  logic   illegal_flag;
  ctrl_t  dec_ctrl;
  logic   dec_load, dec_ebreak, dec_illegal;
  logic   issue_stop;

  pipe_decode u_decode (
    .inst       (inst),
    .alu_zero   (alu_zero),
    .ctrl       (dec_ctrl),
    .is_load    (dec_load),
    .is_ebreak  (dec_ebreak),
    .is_illegal (dec_illegal)
  );

  assign issue_stop = dec_ebreak | dec_illegal;

  // Next-state and combinational control outputs per state.
  always_comb begin
    state_next = state;
    ctrl       = '0;
    pc_en      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (run) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (issue_stop) begin
          state_next = ST_HALT;
        end else begin
          ctrl  = dec_ctrl;
          pc_en = ~dec_load;
          if (dec_load)
            state_next = ST_LOAD2;
          else if (dec_ctrl[CTRL_PC_SEL])
            state_next = ST_BUBBLE;
        end
      end
      ST_LOAD2: begin
        ctrl       = load2_ctrl();
        pc_en      = 1'b1;
        state_next = ST_RUN;
      end
      ST_BUBBLE: begin
        // Stale fetch after a redirect: advance PC, issue nothing.
        pc_en      = 1'b1;
        state_next = ST_RUN;
      end
      ST_HALT: begin
        state_next = ST_HALT;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign halted  = (state == ST_HALT);
  // Reported in the offending issue cycle already, then held by the flag.
  assign illegal = illegal_flag | ((state == ST_RUN) & dec_illegal);

  // State register and sticky illegal flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      illegal_flag <= 1'b0;
    end else begin
      state <= state_next;
      if (state == ST_RUN && dec_illegal)
        illegal_flag <= 1'b1;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic retire_evt;

  // A load retires on its writeback cycle, everything else on issue.
  assign retire_evt = ((state == ST_RUN) & ~issue_stop & ~dec_load) |
                      (state == ST_LOAD2);

  // Retired-instruction counter, free-running wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      retired <= '0;
    else if (retire_evt)
      retired <= retired + 32'd1;
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: the driver pushes the hand-computed
// expected outputs for each cycle; a monitor on the falling edge pops and
// compares. Retired count is checked when PIPE_CTRL_PERF_EN is defined.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [31:0] inst;
  logic        alu_zero;
  logic [0:12] ctrl;
  logic        pc_en;
  logic        halted;
  logic        illegal;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] retired;
`endif

  pipe_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .inst     (inst),
    .alu_zero (alu_zero),
    .ctrl     (ctrl),
    .pc_en    (pc_en),
    .halted   (halted),
    .illegal  (illegal)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .retired  (retired)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [0:12] ctrl;
    logic        pc_en;
    logic        halted;
    logic        illegal;
    logic [31:0] retired;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_total = 0;
  int   n_pass  = 0;

  // Instruction words
  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_SUB   = 32'h402081B3;
  localparam logic [31:0] I_LW    = 32'h0000A283;
  localparam logic [31:0] I_LB    = 32'h00008283;
  localparam logic [31:0] I_SW    = 32'h0020A223;
  localparam logic [31:0] I_BEQ   = 32'h00208463;
  localparam logic [31:0] I_BNE   = 32'h00209463;
  localparam logic [31:0] I_SRAI  = 32'h4030D293;
  localparam logic [31:0] I_SRLI  = 32'h0030D293;
  localparam logic [31:0] I_ADDIN = 32'hC0008293;
  localparam logic [31:0] I_EBRK  = 32'h00100073;
  localparam logic [31:0] I_ONES  = 32'hFFFFFFFF;

  // Expected ctrl words, written in index order 0..12:
  //                          pc rw rsv sb src op   dw wb
  localparam logic [0:12] C_ZERO  = 13'b0_0_000_0_0_0000_0_0;
  localparam logic [0:12] C_ADD   = 13'b0_1_000_0_0_0000_0_0;
  localparam logic [0:12] C_SUB   = 13'b0_1_000_0_0_1000_0_0;
  localparam logic [0:12] C_LW1   = 13'b0_0_000_0_1_0000_0_0;
  localparam logic [0:12] C_LW2   = 13'b0_1_000_0_1_0000_0_1;
  localparam logic [0:12] C_BR_T  = 13'b1_0_000_1_0_1000_0_0;
  localparam logic [0:12] C_BR_N  = 13'b0_0_000_1_0_1000_0_0;
  localparam logic [0:12] C_SRAI  = 13'b0_1_000_0_1_1101_0_0;
  localparam logic [0:12] C_SRLI  = 13'b0_1_000_0_1_0101_0_0;
  localparam logic [0:12] C_ADDI  = 13'b0_1_000_0_1_0000_0_0;
  localparam logic [0:12] C_SW    = 13'b0_0_000_1_1_0000_1_0;

  // Drive one cycle of inputs (called at posedge+1) and queue its expectation.
  task automatic step(input logic [31:0] i, input logic z, input logic [0:12] c,
                      input logic pe, input logic h, input logic il,
                      input logic [31:0] r, input string nm);
    exp_t x;
    inst     = i;
    alu_zero = z;
    x.ctrl = c; x.pc_en = pe; x.halted = h; x.illegal = il;
    x.retired = r; x.name = nm;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      n_total++;
      if (ctrl === e.ctrl && pc_en === e.pc_en && halted === e.halted &&
          illegal === e.illegal) begin
        n_pass++;
        $display("check %-12s ctrl=%b pc_en=%b halted=%b illegal=%b ok",
                 e.name, ctrl, pc_en, halted, illegal);
      end else begin
        $display("FAIL %-12s got ctrl=%b pc_en=%b halted=%b illegal=%b exp ctrl=%b pc_en=%b halted=%b illegal=%b",
                 e.name, ctrl, pc_en, halted, illegal,
                 e.ctrl, e.pc_en, e.halted, e.illegal);
      end
`ifdef PIPE_CTRL_PERF_EN
      n_total++;
      if (retired === e.retired) n_pass++;
      else $display("FAIL %-12s retired got %0d exp %0d", e.name, retired, e.retired);
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; run = 1'b0; inst = '0; alu_zero = 1'b0;
    @(posedge clk); #1;
    step(I_ADD, 0, C_ZERO, 0, 0, 0, 0, "reset");
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) step(I_ADD, 0, C_ZERO, 0, 0, 0, 0, "idle_run0");
    run = 1'b1;
    step(I_ADD, 0, C_ZERO, 0, 0, 0, 0, "idle_run1");
    run = 1'b0;  // ignored once out of IDLE
    step(I_ADD,   0, C_ADD,  1, 0, 0, 0,  "add");
    step(I_LW,    0, C_LW1,  0, 0, 0, 1,  "lw_issue");
    step(I_LW,    0, C_LW2,  1, 0, 0, 1,  "lw_load2");
    step(I_BEQ,   1, C_BR_T, 1, 0, 0, 2,  "beq_taken");
    step(I_ADD,   0, C_ZERO, 1, 0, 0, 3,  "bubble1");
    step(I_BEQ,   0, C_BR_N, 1, 0, 0, 3,  "beq_nt");
    step(I_BNE,   0, C_BR_T, 1, 0, 0, 4,  "bne_taken");
    step(I_SUB,   0, C_ZERO, 1, 0, 0, 5,  "bubble2");
    step(I_SUB,   0, C_SUB,  1, 0, 0, 5,  "sub");
    step(I_SRAI,  0, C_SRAI, 1, 0, 0, 6,  "srai");
    step(I_SRLI,  0, C_SRLI, 1, 0, 0, 7,  "srli");
    step(I_ADDIN, 0, C_ADDI, 1, 0, 0, 8,  "addi_neg");
    step(I_SW,    0, C_SW,   1, 0, 0, 9,  "sw");
    step(I_BNE,   1, C_BR_N, 1, 0, 0, 10, "bne_nt");
    step(I_EBRK,  0, C_ZERO, 0, 0, 0, 11, "ebreak");
    for (int k = 0; k < 20; k++) begin
      step((k % 2 == 0) ? I_ONES : I_ADD, k[0], C_ZERO, 0, 1, 0, 11, "halt_hold");
    end
    // Asynchronous reset out of HALT; run is low so IDLE holds.
    rst_n = 1'b0; #1; rst_n = 1'b1;
    step(I_ADD, 0, C_ZERO, 0, 0, 0, 0, "rst_from_hlt");
    run = 1'b1;
    step(I_ADD, 0, C_ZERO, 0, 0, 0, 0, "idle_again");
    step(I_LB,  0, C_ZERO, 0, 0, 1, 0, "lb_illegal");
    step(I_ADD, 0, C_ZERO, 0, 1, 1, 0, "lb_halted");
    rst_n = 1'b0; #1; rst_n = 1'b1;
    step(I_ADD, 0, C_ZERO, 0, 0, 0, 0, "rst_clr1");
    step(I_ONES, 0, C_ZERO, 0, 0, 1, 0, "ones_issue");
    step(I_ADD,  0, C_ZERO, 0, 1, 1, 0, "ones_halted");
    step(I_ADD,  0, C_ZERO, 0, 1, 1, 0, "ones_sticky");
    // Mid-cycle pulse must clear halted/illegal before the next edge.
    rst_n = 1'b0; #1; rst_n = 1'b1;
    run = 1'b0;
    step(I_ONES, 0, C_ZERO, 0, 0, 0, 0, "rst_clr2");
    step(I_ONES, 0, C_ZERO, 0, 0, 0, 0, "idle_final");
    repeat (2) @(posedge clk);
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL drain %0d expectations unchecked, required 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
